pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_stage.sv | 101 ++++++++++
 tb/tb_pipe_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// Two-entry (head + skid) pipeline register stage with valid/ready handshake,
// bubble hold, synchronous flush and a saturating back-pressure counter.
module pipe_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RD_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RD_W-1:0]  out_rd,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] head_data_q, skid_data_q;
  logic [RD_W-1:0]  head_rd_q, skid_rd_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             push, pop;

  // Readiness depends only on local state and hold, never on out_ready.
  assign in_ready  = !hold && (state_q != FULL);
  assign out_valid = !hold && (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = out_valid ? head_data_q : '0;
  assign out_rd    = out_valid ? head_rd_q   : '0;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Payload registers load only on a push or a skid-to-head move.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_rd_q   <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      stall_q     <= '0;
    end else begin
      stall_q <= stall_d;
      if (flush) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (push) begin
              head_data_q <= in_data;
              head_rd_q   <= in_rd;
              state_q     <= ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              head_data_q <= in_data;
              head_rd_q   <= in_rd;
            end else if (push) begin
              skid_data_q <= in_data;
              skid_rd_q   <= in_rd;
              state_q     <= FULL;
            end else if (pop) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              head_data_q <= skid_data_q;
              head_rd_q   <= skid_rd_q;
              state_q     <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed vector table, hand sequences
// for counter/reset corners, and random traffic against a queue model.
module tb_pipe_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_rd = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        reset3 = 1'b0, in_valid3 = 1'b0, out_ready3 = 1'b0;
  logic [31:0] in_data3 = '0;
  logic [4:0]  in_rd3 = '0;
  logic        in_ready3, out_valid3;
  logic [31:0] out_data3;
  logic [4:0]  out_rd3;
  logic [1:0]  occupancy3;
  logic [2:0]  stall_cnt3;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipe_stage #(.WIDTH(32), .RD_W(5), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .hold(hold), .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage #(.WIDTH(32), .RD_W(5), .CNT_W(3)) u_dut3 (
    .clock(clock), .reset(reset3),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_rd(in_rd3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_rd(out_rd3),
    .hold(1'b0), .flush(1'b0), .occupancy(occupancy3), .stall_cnt(stall_cnt3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [4:0]  rd;
    logic        ordy, hld, fl;
    logic        ov;
    logic [31:0] od;
    logic [4:0]  ord;
    logic [1:0]  occ;
    logic        ir;
    int          stall;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic iv, input logic [31:0] d, input logic [4:0] rd,
                      input logic ordy, input logic hld, input logic fl,
                      input logic ov, input logic [31:0] od, input logic [4:0] ord,
                      input logic [1:0] occ, input logic ir, input int stall);
    vec_t v;
    v.iv = iv; v.d = d; v.rd = rd; v.ordy = ordy; v.hld = hld; v.fl = fl;
    v.ov = ov; v.od = od; v.ord = ord; v.occ = occ; v.ir = ir; v.stall = stall;
    tbl.push_back(v);
  endtask

  // Behavioural reference: a bounded FIFO of {rd, data} plus a saturating count.
  logic [36:0] mq[$];
  int          mstall;

  initial begin
    int          cyc;
    logic        m_ir, m_ov, m_push, m_pop;
    logic [31:0] m_od;
    logic [4:0]  m_ord;

    // Each row: inputs for one cycle, and the outputs expected during that cycle.
    //   iv  data   rd ordy hld fl | ov  od    ord occ ir stall
    addv(1, 32'h11, 1, 1, 0, 0,   0, 0,       0, 0, 1, 0);
    addv(1, 32'h22, 2, 1, 0, 0,   1, 32'h11,  1, 1, 1, 0);
    addv(1, 32'h33, 3, 1, 0, 0,   1, 32'h22,  2, 1, 1, 0);
    addv(0, 0,      0, 1, 0, 0,   1, 32'h33,  3, 1, 1, 0);
    addv(1, 32'hA0, 3, 0, 0, 0,   0, 0,       0, 0, 1, 0);
    addv(1, 32'hB0, 4, 0, 0, 0,   1, 32'hA0,  3, 1, 1, 0);
    addv(0, 0,      0, 0, 0, 0,   1, 32'hA0,  3, 2, 0, 1);
    addv(0, 0,      0, 1, 0, 0,   1, 32'hA0,  3, 2, 0, 2);
    addv(0, 0,      0, 1, 0, 0,   1, 32'hB0,  4, 1, 1, 2);
    addv(0, 0,      0, 1, 0, 0,   0, 0,       0, 0, 1, 2);
    addv(1, 32'h55, 7, 0, 0, 0,   0, 0,       0, 0, 1, 2);
    addv(1, 32'h99, 9, 1, 1, 0,   0, 0,       0, 1, 0, 2);
    addv(1, 32'h99, 9, 1, 1, 0,   0, 0,       0, 1, 0, 2);
    addv(1, 32'h99, 9, 1, 1, 0,   0, 0,       0, 1, 0, 2);
    addv(0, 0,      0, 1, 0, 0,   1, 32'h55,  7, 1, 1, 2);
    addv(0, 0,      0, 1, 0, 0,   0, 0,       0, 0, 1, 2);
    addv(1, 32'hC1, 1, 0, 0, 0,   0, 0,       0, 0, 1, 2);
    addv(1, 32'hC2, 2, 0, 0, 0,   1, 32'hC1,  1, 1, 1, 2);
    addv(1, 32'h77, 5, 0, 0, 1,   1, 32'hC1,  1, 2, 0, 3);
    addv(0, 0,      0, 1, 0, 0,   0, 0,       0, 0, 1, 4);
    addv(1, 32'h88, 6, 0, 0, 0,   0, 0,       0, 0, 1, 4);
    addv(1, 32'h77, 5, 1, 0, 1,   1, 32'h88,  6, 1, 1, 4);
    addv(0, 0,      0, 1, 0, 0,   0, 0,       0, 0, 1, 4);
    addv(1, 32'h44, 4, 0, 0, 0,   0, 0,       0, 0, 1, 4);
    addv(0, 0,      0, 1, 1, 1,   0, 0,       0, 1, 0, 4);
    addv(0, 0,      0, 1, 0, 0,   0, 0,       0, 0, 1, 4);

    // Reset state, observed while reset is still low.
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_od", out_data, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clock);
      in_valid = tbl[i].iv; in_data = tbl[i].d; in_rd = tbl[i].rd;
      out_ready = tbl[i].ordy; hold = tbl[i].hld; flush = tbl[i].fl;
      #1;
      chk($sformatf("vec%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d_od", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d_ord", i), out_rd, tbl[i].ord);
      chk($sformatf("vec%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("vec%0d_ir", i), in_ready, tbl[i].ir);
      chk($sformatf("vec%0d_stall", i), stall_cnt, tbl[i].stall);
    end

    // Counter: fresh reset, one entry, five back-pressured edges.
    @(negedge clock);
    reset = 1'b0; in_valid = 0; out_ready = 0; hold = 0; flush = 0;
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1; in_data = 32'hDEAD; in_rd = 5'd2;
    @(negedge clock);
    in_valid = 0;
    repeat (5) @(negedge clock);
    chk("stall5", stall_cnt, 5);
    chk("stall5_occ", occupancy, 1);
    // Asynchronous reset mid-cycle, no clock edge in between.
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_stall", stall_cnt, 0);
    chk("async_occ", occupancy, 0);
    chk("async_ov", out_valid, 0);
    chk("async_od", out_data, 0);
    // First push on the first edge after release; no stale entry survives.
    @(negedge clock);
    reset = 1'b1; in_valid = 1; in_data = 32'h1234; in_rd = 5'd9; out_ready = 0;
    #1 chk("post_rst_ov", out_valid, 0);
    @(negedge clock);
    in_valid = 0;
    #1;
    chk("first_push_occ", occupancy, 1);
    chk("first_push_od", out_data, 32'h1234);
    chk("first_push_rd", out_rd, 9);

    // Saturation on a 3-bit counter.
    @(negedge clock);
    reset3 = 1'b1; in_valid3 = 1; in_data3 = 32'h5; in_rd3 = 5'd1; out_ready3 = 0;
    @(negedge clock);
    in_valid3 = 0;
    repeat (10) @(negedge clock);
    chk("sat3", stall_cnt3, 7);

    // Random traffic against the queue model.
    @(negedge clock);
    reset = 1'b0; in_valid = 0; out_ready = 0; hold = 0; flush = 0;
    mq.delete(); mstall = 0;
    @(negedge clock);
    reset = 1'b1;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clock);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_rd     = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 2) != 0);
      hold      = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      m_ir  = !hold && (mq.size() < 2);
      m_ov  = !hold && (mq.size() > 0);
      m_od  = m_ov ? mq[0][31:0] : 32'h0;
      m_ord = m_ov ? mq[0][36:32] : 5'h0;
      chk("rnd_ir", in_ready, m_ir);
      chk("rnd_ov", out_valid, m_ov);
      chk("rnd_od", out_data, m_od);
      chk("rnd_ord", out_rd, m_ord);
      chk("rnd_occ", occupancy, mq.size());
      chk("rnd_stall", stall_cnt, mstall);
      m_push = in_valid && m_ir;
      m_pop  = m_ov && out_ready;
      if (m_ov && !out_ready && mstall < 65535) mstall++;
      if (flush) mq.delete();
      else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back({in_rd, in_data});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
